// File: rtl/serdesphy_pll_pkg.sv
// Shared state encoding and default tuning constants for the PHY PLL lock controller.
package serdesphy_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_RETUNE = 3'd3,
    ST_TRACK  = 3'd4,
    ST_LOCKED = 3'd5,
    ST_FAULT  = 3'd6
  } pll_state_e;

  localparam int unsigned PLL_SETTLE_DEF      = 64;
  localparam logic [7:0]  PLL_RAIL_LO_DEF     = 8'h10;
  localparam logic [7:0]  PLL_RAIL_HI_DEF     = 8'hF0;
  localparam int unsigned PLL_LOCK_WIN_DEF    = 4;
  localparam int unsigned PLL_UNLOCK_WIN_DEF  = 12;
  localparam int unsigned PLL_LOCK_COUNT_DEF  = 256;
  localparam int unsigned PLL_BAND_W_DEF      = 3;
  localparam logic [2:0]  PLL_BAND_DEF        = 3'd4;
  localparam int unsigned PLL_MAX_RETUNE_DEF  = 15;

endpackage

// File: rtl/serdesphy_pll_stability_mon.sv
// Tracks the VCO control word against a reference and counts consecutive in-window cycles.
module serdesphy_pll_stability_mon #(
  parameter int unsigned LOCK_WINDOW   = 4,
  parameter int unsigned UNLOCK_WINDOW = 12,
  parameter int unsigned LOCK_COUNT    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       count_i,
  input  logic [7:0] vco_control_i,
  output logic       within_lock_o,
  output logic       beyond_unlock_o,
  output logic       stable_done_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_COUNT - 1);
  localparam logic [8:0] LOCK_WIN_9   = 9'(LOCK_WINDOW);
  localparam logic [8:0] UNLOCK_WIN_9 = 9'(UNLOCK_WINDOW);

  logic [7:0]       ref_q, ref_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [8:0]       diff;

  always_comb begin
    if (vco_control_i >= ref_q) diff = {1'b0, vco_control_i} - {1'b0, ref_q};
    else                        diff = {1'b0, ref_q} - {1'b0, vco_control_i};
  end

  assign within_lock_o   = (diff <= LOCK_WIN_9);
  assign beyond_unlock_o = (diff > UNLOCK_WIN_9);
  assign stable_done_o   = within_lock_o && (stable_q >= STABLE_LAST);

  // An out-of-window sample becomes the new reference, restarting the run.
  always_comb begin
    ref_d    = ref_q;
    stable_d = stable_q;
    if (load_i) begin
      ref_d    = vco_control_i;
      stable_d = '0;
    end else if (count_i) begin
      if (within_lock_o) begin
        if (stable_q != '1) stable_d = stable_q + 1'b1;
      end else begin
        ref_d    = vco_control_i;
        stable_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q    <= '0;
      stable_q <= '0;
    end else begin
      ref_q    <= ref_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/serdesphy_pll_lock_ctrl.sv
// PLL sequencing controller: loop filter enable, coarse band calibration, lock detect and fault.
module serdesphy_pll_lock_ctrl
  import serdesphy_pll_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = PLL_SETTLE_DEF,
  parameter logic [7:0]  RAIL_LO       = PLL_RAIL_LO_DEF,
  parameter logic [7:0]  RAIL_HI       = PLL_RAIL_HI_DEF,
  parameter int unsigned LOCK_WINDOW   = PLL_LOCK_WIN_DEF,
  parameter int unsigned UNLOCK_WINDOW = PLL_UNLOCK_WIN_DEF,
  parameter int unsigned LOCK_COUNT    = PLL_LOCK_COUNT_DEF,
  parameter int unsigned BAND_W        = PLL_BAND_W_DEF,
  parameter int unsigned MAX_RETUNE    = PLL_MAX_RETUNE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_en,
  input  logic [7:0]        vco_control,
  output logic              lf_enable,
  output logic [BAND_W-1:0] vco_band,
  output logic              pll_lock,
  output logic              pll_fault,
  output logic              cal_busy,
  output logic [2:0]        state_dbg
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned RT_W  = ($clog2(MAX_RETUNE + 1) > 4) ? $clog2(MAX_RETUNE + 1) : 4;
  localparam logic [SET_W-1:0]  SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [RT_W-1:0]   RETUNE_LIMIT = RT_W'(MAX_RETUNE);
  localparam logic [BAND_W-1:0] BAND_RESET   = BAND_W'(1) << (BAND_W - 1);
  localparam logic [BAND_W-1:0] BAND_TOP     = '1;

  pll_state_e        state_q;
  logic [BAND_W-1:0] band_q;
  logic [RT_W-1:0]   retune_q;
  logic [SET_W-1:0]  settle_q;
  logic              lf_q, lock_q, fault_q, busy_q;

  logic rail_hi, rail_lo, rail_hit;
  logic within_lock, beyond_unlock, stable_done;
  logic mon_load, mon_count;

  assign rail_hi  = (vco_control >= RAIL_HI);
  assign rail_lo  = (vco_control <= RAIL_LO);
  assign rail_hit = rail_hi || rail_lo;

  // Reference is captured every CHECK cycle; only the TRACK exit actually consumes it.
  assign mon_load  = (state_q == ST_CHECK) ||
                     ((state_q == ST_LOCKED) && beyond_unlock && !rail_hit);
  assign mon_count = pll_en && (state_q == ST_TRACK) && !rail_hit;

  serdesphy_pll_stability_mon #(
    .LOCK_WINDOW   (LOCK_WINDOW),
    .UNLOCK_WINDOW (UNLOCK_WINDOW),
    .LOCK_COUNT    (LOCK_COUNT)
  ) u_stab (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_i          (mon_load),
    .count_i         (mon_count),
    .vco_control_i   (vco_control),
    .within_lock_o   (within_lock),
    .beyond_unlock_o (beyond_unlock),
    .stable_done_o   (stable_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      band_q   <= BAND_RESET;
      retune_q <= '0;
      settle_q <= '0;
      lf_q     <= 1'b0;
      lock_q   <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!pll_en) begin
      state_q  <= ST_IDLE;
      retune_q <= '0;
      settle_q <= '0;
      lf_q     <= 1'b0;
      lock_q   <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_SETTLE;
          settle_q <= '0;
          lf_q     <= 1'b1;
          busy_q   <= 1'b1;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q  <= ST_CHECK;
          else                         settle_q <= settle_q + 1'b1;
        end
        ST_CHECK: begin
          if (rail_hi && (band_q != BAND_TOP)) begin
            band_q  <= band_q + 1'b1;
            state_q <= ST_RETUNE;
            lf_q    <= 1'b0;
          end else if (rail_lo && (band_q != '0)) begin
            band_q  <= band_q - 1'b1;
            state_q <= ST_RETUNE;
            lf_q    <= 1'b0;
          end else if (rail_hit) begin
            state_q <= ST_FAULT;
            lf_q    <= 1'b0;
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_TRACK;
          end
        end
        ST_RETUNE: begin
          if (retune_q == RETUNE_LIMIT) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            retune_q <= retune_q + 1'b1;
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            lf_q     <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (rail_hit) begin
            state_q <= ST_CHECK;
          end else if (stable_done) begin
            state_q <= ST_LOCKED;
            lock_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (rail_hit) begin
            state_q <= ST_CHECK;
            lock_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (beyond_unlock) begin
            state_q <= ST_TRACK;
            lock_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign lf_enable = lf_q;
  assign vco_band  = band_q;
  assign pll_lock  = lock_q;
  assign pll_fault = fault_q;
  assign cal_busy  = busy_q;
  assign state_dbg = state_q;

endmodule

// File: doc/serdesphy_pll_lock_ctrl.md
Name: serdesphy_pll_lock_ctrl

Overview:
Sequencing controller for the PHY PLL analog model. It enables the loop filter, runs coarse VCO band calibration by watching the 8-bit VCO control word for rail saturation, and declares lock once the control word stays inside a stability window. It also detects loss of lock and reports calibration faults. It sits between the PHY power/control FSM (pll_en) and the loop filter/VCO pair.

Parameters:
SETTLE_CYCLES, 64, cycles the loop filter runs after enable/retune before the first rail check (>=2)
RAIL_LO, 8'h10, vco_control at or below this value means the band is too high; step band down
RAIL_HI, 8'hF0, vco_control at or above this value means the band is too low; step band up
LOCK_WINDOW, 4, max |vco_control - ref| counted as stable during TRACK
UNLOCK_WINDOW, 12, |vco_control - ref| above this while LOCKED drops lock
LOCK_COUNT, 256, consecutive stable cycles required to declare lock
BAND_W, 3, VCO coarse band select width
MAX_RETUNE, 15, band steps allowed per enable session before FAULT

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pll_en  in  1  PLL enable request from PHY control (level)
vco_control  in  8  loop filter control word
lf_enable  out  1  loop filter enable (low returns the filter to mid-scale)
vco_band  out  BAND_W  coarse VCO band select
pll_lock  out  1  PLL locked
pll_fault  out  1  calibration failed (band exhausted or retune limit reached)
cal_busy  out  1  calibration/acquisition in progress
state_dbg  out  3  current state encoding

Behaviour:
- One clock; reset is synchronous and active-low. rst_n low at a clk edge -> state IDLE, lf_enable=0, vco_band=2**(BAND_W-1) (4), pll_lock=0, pll_fault=0, cal_busy=0, all counters 0. Reset mid-operation behaves identically.
- All outputs are registered. States and encodings: IDLE=0, SETTLE=1, CHECK=2, RETUNE=3, TRACK=4, LOCKED=5, FAULT=6.
- pll_en=0 in any state -> IDLE on the next edge. This overrides every other transition. lf_enable, pll_lock, pll_fault and cal_busy go to 0; vco_band is retained for fast relock; the retune counter is cleared.
- IDLE: pll_en=1 -> SETTLE; lf_enable=1, cal_busy=1, settle counter=0.
- SETTLE: the counter increments each cycle. On the cycle the count reaches SETTLE_CYCLES-1 -> CHECK.
- CHECK (one cycle), evaluated in priority order:
  - vco_control>=RAIL_HI and vco_band<max -> RETUNE with band+1.
  - vco_control<=RAIL_LO and vco_band>0 -> RETUNE with band-1.
  - Rail hit with the band already at its limit (max or 0) -> FAULT.
  - Otherwise -> TRACK; ref<=vco_control, stable counter=0.
- RETUNE (one cycle): vco_band updates and lf_enable=0 for exactly this cycle. Retune counter +1.
  - If the retune counter was already MAX_RETUNE -> FAULT.
  - Otherwise -> SETTLE with lf_enable=1 and settle counter=0.
- TRACK: diff=|vco_control-ref|, computed 9-bit and unsigned.
  - diff<=LOCK_WINDOW: stable counter +1. When it reaches LOCK_COUNT-1 -> LOCKED, and pll_lock=1 from the next cycle.
  - diff>LOCK_WINDOW: ref<=vco_control, stable counter=0.
  - A rail hit (RAIL_HI/RAIL_LO) in TRACK -> CHECK. The rail check has priority over counting.
- LOCKED: pll_lock=1, cal_busy=0.
  - diff>UNLOCK_WINDOW -> TRACK with pll_lock=0, cal_busy=1, ref<=vco_control, stable counter=0.
  - A rail hit -> CHECK with pll_lock=0.
- FAULT: lf_enable=0, pll_fault=1, cal_busy=0. Held until pll_en=0.
- Counters saturate and never wrap. The stable counter is wide enough for LOCK_COUNT. The retune counter is 4 bits minimum.

Decomposition:
- Shared package serdesphy_pll_pkg: state enum/localparams (IDLE..FAULT), default band constant, rail and window defaults.
- One natural sub-module, serdesphy_pll_stability_mon. It holds the ref register, the abs-diff compare, and the stable counter; its outputs are within_lock, beyond_unlock and stable_done.
- The FSM, band register and retune counter stay in the top module.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, pll_en=0 -> all outputs 0, vco_band=4, state_dbg=0. Assert rst_n=0 mid-TRACK -> same values on the next edge.
- Direct lock: pll_en=1, vco_control fixed at 8'h80 -> SETTLE for 64 cycles, then 1 CHECK cycle, then pll_lock=1 after 256 TRACK cycles. vco_band stays 4, cal_busy falls with lock.
- Band up: vco_control=8'hF8 at CHECK -> one RETUNE cycle with lf_enable=0 and vco_band=5. Then vco_control=8'h80 -> lock at band 5.
- Band exhaust: vco_control held at 8'h05 -> band steps 4,3,2,1,0, then FAULT. Check pll_fault=1 and lf_enable=0; pll_en=0 clears the fault, and the band stays 0.
- Lock loss: after lock, step vco_control from 8'h80 to 8'h8D (diff 13) -> pll_lock=0 next cycle, state TRACK. Hold 8'h8D for 256 cycles -> relock.
- Window edge: jitter vco_control between 8'h80 and 8'h84 in TRACK -> lock reached. A single 8'h85 resets the stable count and ref to 8'h85.
